// File: rtl/key_pio_pkg.sv
// Key PIO register map and the poll master's state encoding.
package key_pio_pkg;

    localparam logic [1:0] KEY_OFS_DATA = 2'd0;
    localparam logic [1:0] KEY_OFS_MASK = 2'd2;
    localparam logic [1:0] KEY_OFS_EDGE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_EDGE,
        ST_WT_EDGE,
        ST_WR_CLR,
        ST_RD_DATA,
        ST_WT_DATA,
        ST_REPORT
    } kpm_state_e;

endpackage

// File: rtl/poll_timer.sv
// Reloadable down-counter: counts toward zero while enabled, then sits at zero
// until reloaded.
module poll_timer #(
    parameter int unsigned PERIOD = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic reload,
    output logic zero
);

    localparam int unsigned     CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || reload) begin
            count <= LOAD;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/key_poll_master.sv
// Avalon-MM master that polls the key PIO edge_capture register, clears it,
// snapshots the key levels and offers the result as a single valid/ready event.
module key_poll_master
    import key_pio_pkg::*;
#(
    parameter int unsigned       WIDTH       = 2,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       POLL_PERIOD = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    output logic              event_valid,
    input  logic              event_ready,
    output logic [WIDTH-1:0]  event_edges,
    output logic [WIDTH-1:0]  event_levels
);

    function automatic logic [ADDR_W-1:0] reg_addr(input logic [1:0] ofs);
        return BASE_ADDR + ADDR_W'({ofs, 2'b00});
    endfunction

    kpm_state_e       state;
    logic [WIDTH-1:0] edges_q;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_vld;
    logic             rsp_cap;
    logic             accept;
    logic             rd_state;
    logic             wt_state;
    logic             tmr_run;
    logic             tmr_zero;
    logic             unused_readdata;

    assign unused_readdata = ^avm_readdata;

    assign accept   = (avm_read || avm_write) && !avm_waitrequest;
    assign rd_state = (state == ST_RD_EDGE) || (state == ST_RD_DATA);
    assign wt_state = (state == ST_WT_EDGE) || (state == ST_WT_DATA);

    // A response is captured either while waiting or on the very edge the read
    // is accepted (zero-latency slave); strobes in any other state are dropped.
    assign rsp_cap = avm_readdatavalid && ((wt_state && !rsp_vld) || (rd_state && accept));

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld  <= 1'b0;
            rsp_data <= '0;
        end else begin
            rsp_vld <= rsp_cap;
            if (rsp_cap) begin
                rsp_data <= avm_readdata[WIDTH-1:0];
            end
        end
    end

    assign tmr_run = (state == ST_IDLE) && enable;

    poll_timer #(
        .PERIOD (POLL_PERIOD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (tmr_run),
        .reload (tmr_run && tmr_zero),
        .zero   (tmr_zero)
    );

    // Commands are launched on the edge that enters their state, so the bus
    // registers stay stable for as long as waitrequest holds them off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_INIT;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= BASE_ADDR;
            avm_writedata <= '0;
            edges_q       <= '0;
            event_valid   <= 1'b0;
            event_edges   <= '0;
            event_levels  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (!avm_write) begin
                        avm_write     <= 1'b1;
                        avm_address   <= reg_addr(KEY_OFS_MASK);
                        avm_writedata <= '0;
                    end else if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (enable && tmr_zero) begin
                        avm_read    <= 1'b1;
                        avm_address <= reg_addr(KEY_OFS_EDGE);
                        state       <= ST_RD_EDGE;
                    end
                end
                ST_RD_EDGE: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= ST_WT_EDGE;
                    end
                end
                ST_WT_EDGE: begin
                    if (rsp_vld) begin
                        edges_q <= rsp_data;
                        if (rsp_data == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            avm_write     <= 1'b1;
                            avm_address   <= reg_addr(KEY_OFS_EDGE);
                            avm_writedata <= 32'(rsp_data);
                            state         <= ST_WR_CLR;
                        end
                    end
                end
                ST_WR_CLR: begin
                    if (!avm_waitrequest) begin
                        avm_write   <= 1'b0;
                        avm_read    <= 1'b1;
                        avm_address <= reg_addr(KEY_OFS_DATA);
                        state       <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= ST_WT_DATA;
                    end
                end
                ST_WT_DATA: begin
                    if (rsp_vld) begin
                        event_edges  <= edges_q;
                        event_levels <= rsp_data;
                        event_valid  <= 1'b1;
                        state        <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (event_valid && event_ready) begin
                        event_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_key_poll_master.sv
// Bench for key_poll_master: a behavioural key PIO slave plus a transaction-level
// expectation of the poll sequence, checked at every falling edge.
module tb_key_poll_master;

    localparam int          W     = 2;
    localparam int          P     = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [W-1:0] WMASK = '1;

    typedef enum int {OP_MASK, OP_RDE, OP_WAITE, OP_CLR, OP_RDD, OP_WAITD, OP_EVT} op_e;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic [31:0]   avm_address, avm_writedata, avm_readdata;
    logic          avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic          event_valid, event_ready;
    logic [W-1:0]  event_edges, event_levels;

    key_poll_master #(
        .WIDTH(W), .ADDR_W(32), .BASE_ADDR(BASE), .POLL_PERIOD(P)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .event_valid(event_valid), .event_ready(event_ready),
        .event_edges(event_edges), .event_levels(event_levels)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // slave contents and expected transaction flow
    op_e          exp_op = OP_MASK;
    logic [W-1:0] key_edges = '0, key_levels = '0;
    logic [W-1:0] exp_edges = '0, exp_levels = '0;
    int           rsp_cnt = -1;
    logic [31:0]  rsp_word = '0;
    bit           rd_out = 0;
    int           gap = -1;
    bit           gap_exact = 0, gap_en = 0;
    int           evt_wait = 0;

    // previous-cycle samples
    logic         p_read = 0, p_write = 0, p_wr = 0, p_ev = 0, p_rdy = 0, p_en = 0;
    logic [31:0]  p_addr = '0, p_wd = '0;
    logic [W-1:0] p_ee = '0, p_el = '0;

    // knobs
    bit rst_drv = 1, en_drv = 1, rand_wr = 0, rand_rdy = 0, hold_rdy = 0, inject = 0;
    bit stall_req = 0, stall_seen = 0;
    int stall_left = 0, force_lat = -1;

    // statistics
    int           n_writes = 0, n_edge_reads = 0, n_events = 0;
    logic [31:0]  last_clr_wd = '0;
    logic [W-1:0] last_ev_e = '0, last_ev_l = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic deliver();
        avm_readdatavalid = 1'b1;
        avm_readdata      = rsp_word;
        rd_out            = 0;
        if (exp_op == OP_WAITE) begin
            if (exp_edges == '0) begin
                exp_op = OP_RDE; gap = 0; gap_exact = 0; gap_en = en_drv;
            end else begin
                exp_op = OP_CLR;
            end
        end else if (exp_op == OP_WAITD) begin
            exp_op = OP_EVT; evt_wait = 0;
        end
    endtask

    task automatic schedule();
        int lat;
        lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        if (lat == 0) deliver();
        else rsp_cnt = lat - 1;
    endtask

    task automatic step();
        bit cmd, acc, wr;
        @(negedge clk);
        cmd = avm_read | avm_write;

        if (reset) begin
            chk("rst_read", 32'(avm_read), 32'd0);
            chk("rst_write", 32'(avm_write), 32'd0);
            chk("rst_addr", avm_address, BASE);
            chk("rst_wdata", avm_writedata, 32'd0);
            chk("rst_evt", 32'({event_valid, event_edges, event_levels}), 32'd0);
        end else begin
            chk("rd_wr_excl", 32'(avm_read & avm_write), 32'd0);
            if ((p_read | p_write) && p_wr) begin
                chk("hold_cmd", 32'({avm_read, avm_write}), 32'({p_read, p_write}));
                chk("hold_addr", avm_address, p_addr);
                chk("hold_wdata", avm_writedata, p_wd);
            end
            if (event_valid) begin
                chk("evt_expected", 32'(exp_op == OP_EVT), 32'd1);
                chk("evt_edges", 32'(event_edges), 32'(exp_edges));
                chk("evt_levels", 32'(event_levels), 32'(exp_levels));
                chk("evt_no_cmd", 32'(cmd), 32'd0);
            end else if (exp_op == OP_EVT) begin
                evt_wait++;
                if (evt_wait == 8) chk("evt_timeout", 32'(event_valid), 32'd1);
            end
            if (p_ev && !p_rdy)
                chk("evt_hold", 32'({event_valid, event_edges, event_levels}),
                    32'({1'b1, p_ee, p_el}));
            if (avm_read && !p_read && !p_write && exp_op == OP_RDE) begin
                chk("en_at_poll", 32'(p_en), 32'd1);
                if (gap >= 0 && gap_en) begin
                    if (gap_exact) chk("poll_gap", 32'(gap), 32'(P));
                    else chk("poll_gap_range", 32'(gap), (gap == P + 1) ? 32'(P + 1) : 32'(P));
                end
                gap = -1;
            end else if (!cmd && gap >= 0) begin
                gap++;
            end
        end

        // slave: waitrequest, responses, command acceptance
        if (stall_req && exp_op == OP_CLR && avm_write) begin
            stall_left = 5; stall_req = 0; stall_seen = 1;
        end
        if (stall_left > 0) begin wr = 1; stall_left--; end
        else wr = rand_wr ? ($urandom_range(0, 3) == 0) : 1'b0;
        acc = cmd && !wr && !rst_drv;

        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
        if (rsp_cnt == 0) begin deliver(); rsp_cnt = -1; end
        else if (rsp_cnt > 0) rsp_cnt--;

        if (acc) begin
            if (avm_read) begin chk("one_outstanding", 32'(rd_out), 32'd0); rd_out = 1; end
            case (exp_op)
                OP_MASK: begin
                    chk("mask_cmd", 32'({avm_write, avm_read}), 32'b10);
                    chk("mask_addr", avm_address, BASE + 32'd8);
                    chk("mask_data", avm_writedata, 32'd0);
                    n_writes++; exp_op = OP_RDE; gap = 0; gap_exact = 1; gap_en = en_drv;
                end
                OP_RDE: begin
                    chk("rde_cmd", 32'({avm_write, avm_read}), 32'b01);
                    chk("rde_addr", avm_address, BASE + 32'd12);
                    exp_edges = key_edges;
                    rsp_word  = ($urandom & ~32'(WMASK)) | 32'(key_edges);
                    n_edge_reads++; exp_op = OP_WAITE; schedule();
                end
                OP_CLR: begin
                    chk("clr_cmd", 32'({avm_write, avm_read}), 32'b10);
                    chk("clr_addr", avm_address, BASE + 32'd12);
                    chk("clr_data", avm_writedata, 32'(exp_edges));
                    key_edges = '0; last_clr_wd = avm_writedata;
                    n_writes++; exp_op = OP_RDD;
                end
                OP_RDD: begin
                    chk("rdd_cmd", 32'({avm_write, avm_read}), 32'b01);
                    chk("rdd_addr", avm_address, BASE);
                    exp_levels = key_levels;
                    rsp_word   = ($urandom & ~32'(WMASK)) | 32'(key_levels);
                    exp_op = OP_WAITD; schedule();
                end
                default: chk("unexpected_cmd", 32'({avm_read, avm_write}), 32'd0);
            endcase
        end

        if (hold_rdy) event_ready = 1'b0;
        else event_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!rst_drv && event_valid && event_ready && exp_op == OP_EVT) begin
            n_events++; last_ev_e = event_edges; last_ev_l = event_levels;
            exp_op = OP_RDE; gap = 0; gap_exact = 1; gap_en = en_drv;
        end

        if (rst_drv) begin
            exp_op = OP_MASK; rd_out = 0; gap = -1; evt_wait = 0;
        end
        if (!en_drv) gap_en = 0;

        if (inject && $urandom_range(0, 7) == 0) key_edges = key_edges | W'($urandom);
        if (inject && $urandom_range(0, 3) == 0) key_levels = W'($urandom);

        p_read = avm_read; p_write = avm_write; p_addr = avm_address; p_wd = avm_writedata;
        p_ev = event_valid; p_ee = event_edges; p_el = event_levels;
        p_wr = wr; p_rdy = event_ready; p_en = en_drv;
        avm_waitrequest = wr;
        reset  = rst_drv;
        enable = en_drv;
    endtask

    task automatic wait_events(input int target, input int budget);
        int k;
        k = 0;
        while (n_events < target && k < budget) begin step(); k++; end
        if (n_events < target) chk("wait_event_timeout", 32'(n_events), 32'(target));
    endtask

    task automatic wait_op(input op_e op, input int budget);
        int k;
        k = 0;
        while (exp_op != op && k < budget) begin step(); k++; end
        if (exp_op != op) chk("wait_op_timeout", 32'(exp_op), 32'(op));
    endtask

    initial begin
        int w0, r0, e0, k;
        reset = 1'b1; enable = 1'b1; avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0; avm_readdata = '0; event_ready = 1'b0;
        repeat (3) step();
        rst_drv = 0;

        // INIT write, then empty polls
        repeat (40) step();
        chk("noedge_writes", 32'(n_writes), 32'd1);
        chk("noedge_events", 32'(n_events), 32'd0);
        chk("noedge_polls_ge3", 32'(n_edge_reads >= 3), 32'd1);

        // single event with literal content
        key_edges = 2'b10; key_levels = 2'b01;
        wait_events(1, 80);
        chk("lit_clr_wdata", last_clr_wd, 32'h2);
        chk("lit_evt_edges", 32'(last_ev_e), 32'h2);
        chk("lit_evt_levels", 32'(last_ev_l), 32'h1);

        // waitrequest holding off the clear write
        w0 = n_writes; stall_req = 1; key_edges = 2'b01; key_levels = 2'b10;
        wait_events(n_events + 1, 80);
        chk("stall_seen", 32'(stall_seen), 32'd1);
        chk("stall_one_accept", 32'(n_writes - w0), 32'd1);
        chk("stall_evt_edges", 32'(last_ev_e), 32'h1);

        // consumer back-pressure
        hold_rdy = 1; key_edges = 2'b11;
        k = 0;
        while (!(event_valid === 1'b1) && k < 80) begin step(); k++; end
        repeat (20) step();
        chk("bp_valid_held", 32'(event_valid), 32'd1);
        chk("bp_edges", 32'(event_edges), 32'h3);
        hold_rdy = 0;
        step();
        step();
        chk("bp_valid_drop", 32'(event_valid), 32'd0);
        repeat (15) step();

        // enable falls mid-sequence: sequence completes, then parks
        key_edges = 2'b10;
        wait_op(OP_CLR, 80);
        en_drv = 0; e0 = n_events;
        wait_events(e0 + 1, 40);
        r0 = n_edge_reads;
        repeat (30) step();
        chk("parked_no_poll", 32'(n_edge_reads), 32'(r0));
        en_drv = 1;

        // randomized traffic
        e0 = n_events; rand_wr = 1; rand_rdy = 1; inject = 1;
        repeat (3000) step();
        chk("rand_events_ge10", 32'(n_events - e0 >= 10), 32'd1);

        // reset while waiting for the edge response
        rand_wr = 0; rand_rdy = 0; inject = 0;
        wait_events(n_events + 0, 1);
        wait_op(OP_RDE, 80);
        key_edges = 2'b01; force_lat = 2;
        wait_op(OP_WAITE, 80);
        rst_drv = 1; en_drv = 0; e0 = n_events; w0 = n_writes;
        step();
        rst_drv = 0; force_lat = -1;
        repeat (20) step();
        chk("rst_init_rewrite", 32'(n_writes - w0), 32'd1);
        chk("rst_no_event", 32'(n_events), 32'(e0));
        en_drv = 1;
        wait_events(e0 + 1, 80);
        chk("rst_edge_kept", 32'(last_ev_e), 32'h1);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_poll_master.md
Name: key_poll_master

Overview:
- Avalon-MM master that drives the key PIO slave's register map (data @0, irq_mask @2, edge_capture @3; word offsets).
- Used in place of the PIO interrupt: polls edge_capture on a fixed period, clears it, snapshots the key levels, and hands a one-entry event to fabric logic through a valid/ready handshake.
- Sits on the same interconnect as the Nios II, as a second master targeting the key PIO.

Parameters:
- WIDTH, 2, number of key bits used from each slave register (1..32).
- ADDR_W, 32, master byte-address width.
- BASE_ADDR, 32'h0, byte base address of the key PIO slave.
- POLL_PERIOD, 50000, idle cycles between polls (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  polling enable; sampled only in IDLE.
- avm_address  out  ADDR_W  byte address: BASE_ADDR + 4*offset.
- avm_read  out  1  read command.
- avm_write  out  1  write command.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read response strobe.
- event_valid  out  1  event available.
- event_ready  in  1  consumer accepts event.
- event_edges  out  WIDTH  edge bits captured by the poll.
- event_levels  out  WIDTH  key levels read after the clear.

Behaviour:
- Reset is synchronous and active-high; one clock domain (clk) only. Reset values: avm_read=0, avm_write=0, avm_address=BASE_ADDR, avm_writedata=0, event_valid=0, event_edges=0, event_levels=0, counter=POLL_PERIOD-1, state=INIT.
- Command rule:
  - A command is accepted on a clk edge with (read|write) && !avm_waitrequest.
  - While waitrequest=1, address, writedata, read and write hold stable.
  - read and write are never asserted together.
  - At most one read is outstanding.
- States:
  - INIT: write 0 to offset 2 (irq_mask=0). On accept -> IDLE.
  - IDLE: counter decrements each cycle while enable=1. At 0 -> RD_EDGE and the counter reloads to POLL_PERIOD-1. While enable=0 the counter holds its reloaded value.
  - RD_EDGE: read offset 3. On accept -> WT_EDGE.
  - WT_EDGE: on readdatavalid, latch edges = readdata[WIDTH-1:0]. Edges=0 -> IDLE; otherwise -> WR_CLR.
  - WR_CLR: write the latched edges (zero-extended) to offset 3. On accept -> RD_DATA.
  - RD_DATA: read offset 0. On accept -> WT_DATA.
  - WT_DATA: on readdatavalid, latch levels = readdata[WIDTH-1:0]. Load event_edges/event_levels, set event_valid=1 -> REPORT.
  - REPORT: hold outputs stable. On event_valid && event_ready, clear event_valid -> IDLE.
- Poll interval = POLL_PERIOD idle cycles plus transaction time. Polling stalls while REPORT is unacknowledged; the slave's sticky edge_capture holds pending edges meanwhile.
- readdatavalid may arrive on the same edge as the accepted read. The FSM samples it in WT_* only; readdatavalid in any other state is ignored.
- Zero-latency response (accept and readdatavalid on the same edge) completes in WT_* the following cycle; readdata is registered on the same edge readdatavalid is seen.
- enable falling mid-sequence: the current sequence completes; the FSM then parks in IDLE.
- Reset mid-transaction: commands drop on the next edge. A late readdatavalid is ignored. INIT reruns.
- Known limitation: the slave's clear write clears all edge bits. An edge arriving between RD_EDGE and WR_CLR is lost. This is accepted.
- Readdata bits above WIDTH are ignored.

Decomposition:
- Shared package key_pio_pkg:
  - register offsets KEY_OFS_DATA=0, KEY_OFS_MASK=2, KEY_OFS_EDGE=3;
  - state enum typedef.
- Sub-module poll_timer: reloadable down-counter with enable, reload and a zero flag.
- The FSM and the Avalon command register stay in the top level.

Test Plan:
- Reset, waitrequest=0 -> first command is a write to BASE+8 with data 0; then IDLE with no commands for POLL_PERIOD cycles.
- POLL_PERIOD=4, edge read returns 0 -> one read of BASE+12 every 4 idle cycles plus transaction time; no write; event_valid stays 0.
- Edge read returns 32'h2, data read returns 32'h1 -> write BASE+12 with 32'h2, read BASE+0; event_valid=1, event_edges=2'b10, event_levels=2'b01.
- waitrequest held high 5 cycles during WR_CLR -> address/writedata/write stable all 5 cycles; exactly one accept.
- event_ready=0 for 20 cycles -> outputs frozen, no Avalon commands issued; event_ready=1 -> event_valid drops next cycle, polling resumes.
- Reset asserted in WT_EDGE, readdatavalid arrives next cycle -> data ignored, INIT write issued, no event produced.
